// File: rtl/jk_register_controller_pkg.sv
// Shared definitions for the JK register controller.
// Holds the opcode constants, the FSM state encoding and the helper that
// flags illegal opcodes.
package jk_register_controller_pkg;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_RESET  = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_COUNT  = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Opcodes 6 and 7 are undefined; they act as NOP and raise err.
  function automatic logic op_illegal(input logic [2:0] op);
    return (op > OP_COUNT);
  endfunction

endpackage

// File: rtl/jk_register_controller_jkff.sv
// Positive-edge JK flip-flop with asynchronous active-low clear.
// Ports: clk, clr_bar (async clear), j, k (drive), q, q_bar (state and complement).
module jk_flip_flop (
  input  logic clk,
  input  logic clr_bar,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);

  always_ff @(posedge clk or negedge clr_bar) begin
    if (!clr_bar) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign q_bar = ~q;

endmodule

// File: rtl/jk_register_controller.sv
// Command sequencer driving a WIDTH-bit bank of JK flip-flops.
// Ports:
//   clk, clr_bar          clock and async active-low reset (controller + bank)
//   cmd_valid, cmd_ready  command handshake; ready only while IDLE
//   cmd_op, cmd_data      opcode and data/mask/step count
//   q                     register contents
//   busy, done, err       status: not-IDLE, completion pulse, illegal-op flag
module jk_register_controller
  import jk_register_controller_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_bar,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] remaining;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q_bar;
  logic [WIDTH-1:0] toggle;
  logic             carry;

  // FSM with registered status outputs; each transition sets the outputs
  // that belong to the destination state.
  always_ff @(posedge clk or negedge clr_bar) begin
    if (!clr_bar) begin
      state     <= IDLE;
      op_q      <= '0;
      data_q    <= '0;
      remaining <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            data_q    <= cmd_data;
            remaining <= cmd_data;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_op != OP_COUNT) begin
              state <= APPLY;
            end else if (cmd_data != '0) begin
              state <= COUNT;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        APPLY: begin
          state <= DONE;
          done  <= 1'b1;
          err   <= op_illegal(op_q);
        end
        COUNT: begin
          remaining <= remaining - 1'b1;
          if (remaining == {{(WIDTH-1){1'b0}}, 1'b1}) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
          err       <= 1'b0;
        end
      endcase
    end
  end

  // Ripple-carry increment expressed as JK toggles: bit i toggles when
  // every lower bit is one.
  always_comb begin
    toggle = '0;
    carry  = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      toggle[i] = carry;
      carry     = carry & q[i];
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    case (state)
      APPLY: begin
        case (op_q)
          OP_LOAD: begin
            j = data_q;
            k = ~data_q;
          end
          OP_SET:    j = data_q;
          OP_RESET:  k = data_q;
          OP_TOGGLE: begin
            j = data_q;
            k = data_q;
          end
          default: ;
        endcase
      end
      COUNT: begin
        j = toggle;
        k = toggle;
      end
      default: ;
    endcase
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    jk_flip_flop u_ff (
      .clk     (clk),
      .clr_bar (clr_bar),
      .j       (j[b]),
      .k       (k[b]),
      .q       (q[b]),
      .q_bar   (q_bar[b])
    );
  end

endmodule
